// File: rtl/spi_flash_responder_pkg.sv
// rtl/spi_flash_responder_pkg.sv - opcodes, FSM states and status-bit indices for the SPI flash responder
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDID      = 8'h9F;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_WRDI      = 8'h04;
    localparam logic [7:0] OP_PP        = 8'h02;
    localparam logic [7:0] OP_SE        = 8'h20;
    localparam logic [7:0] OP_DP        = 8'hB9;
    localparam logic [7:0] OP_RES       = 8'hAB;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DOUT,
        ST_DIN,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// rtl/spi_flash_responder_if.sv - SPI pin bundle; io1 is resolved to high-Z here from data/enable
interface spi_flash_responder_if;
    logic csb;
    logic io0;
    logic io1_d;
    logic io1_oe;
    logic io2;
    logic io3;
    wire  io1;

    assign io1 = io1_oe ? io1_d : 1'bz;

    modport master (output csb, io0, io2, io3, input io1, io1_oe);
    modport slave  (input csb, io0, io2, io3, output io1_d, io1_oe);
endinterface

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 NOR flash responder with read/program/erase/ID/power-down
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          MEM_AW    = 20,
    parameter              INIT_FILE = "",
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016,
    parameter bit          START_PD  = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    spi_flash_responder_if.slave bus
);

    localparam int MEM_SIZE = 1 << MEM_AW;

    logic [7:0] mem [MEM_SIZE] = '{default: 8'hFF};

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt, dummy_last;
    logic [7:0]  shreg, op, tx_byte, din, cur_op, byte_nxt, status;
    logic [23:0] addr, addr_full, cur_addr, addr_nxt;
    logic        wel, pd, areset, cmd_done, pd_block, load_byte, prog_we, erase_we;
    logic        out_d, out_oe;
    logic        unused_io;

    assign unused_io  = ^{bus.io2, bus.io3};
    assign areset     = rst | bus.csb;
    assign din        = {shreg[6:0], bus.io0};
    assign addr_full  = {addr[22:0], bus.io0};
    assign cmd_done   = (state == ST_CMD) && (cnt == 5'd7);
    assign cur_op     = (state == ST_CMD) ? din : op;
    assign cur_addr   = (state == ST_ADDR) ? addr_full : addr;
    assign pd_block   = pd && (din != OP_RES);
    assign dummy_last = (op == OP_RES) ? 5'd23 : 5'd7;
    assign prog_we    = (state == ST_DIN) && (cnt == 5'd7);
    assign erase_we   = (state == ST_ADDR) && (cnt == 5'd23) && (op == OP_SE);

    always_comb begin
        status         = '0;
        status[SR_WEL] = wel;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CMD: if (cnt == 5'd7) begin
                if (pd_block) state_nxt = ST_IGNORE;
                else case (din)
                    OP_READ, OP_FAST_READ: state_nxt = ST_ADDR;
                    OP_PP, OP_SE:          state_nxt = wel ? ST_ADDR : ST_IGNORE;
                    OP_RDID, OP_RDSR:      state_nxt = ST_DOUT;
                    OP_RES:                state_nxt = ST_DUMMY;
                    default:               state_nxt = ST_IGNORE;
                endcase
            end
            ST_ADDR: if (cnt == 5'd23) begin
                case (op)
                    OP_READ:      state_nxt = ST_DOUT;
                    OP_FAST_READ: state_nxt = ST_DUMMY;
                    OP_PP:        state_nxt = ST_DIN;
                    default:      state_nxt = ST_IGNORE;
                endcase
            end
            ST_DUMMY: if (cnt == dummy_last) state_nxt = ST_DOUT;
            default: ;
        endcase
    end

    // DOUT/DIN count bits within a byte; every other state counts from zero on entry
    always_comb begin
        cnt_nxt = cnt + 5'd1;
        if (state_nxt != state || state == ST_IGNORE) cnt_nxt = 5'd0;
        else if (state == ST_DOUT || state == ST_DIN) cnt_nxt = {2'b00, cnt[2:0] + 3'd1};
    end

    assign load_byte = (state_nxt == ST_DOUT) && (state != ST_DOUT || cnt[2:0] == 3'd7);

    // addr doubles as the ID byte index for 0x9F, saturating on the trailing 0xFF
    always_comb begin
        byte_nxt = 8'hFF;
        addr_nxt = cur_addr + 24'd1;
        case (cur_op)
            OP_RDID: begin
                case (cur_addr[1:0])
                    2'd0:    byte_nxt = JEDEC_ID[23:16];
                    2'd1:    byte_nxt = JEDEC_ID[15:8];
                    2'd2:    byte_nxt = JEDEC_ID[7:0];
                    default: byte_nxt = 8'hFF;
                endcase
                if (cur_addr >= 24'd3) addr_nxt = cur_addr;
            end
            OP_RDSR: byte_nxt = status;
            OP_RES:  byte_nxt = JEDEC_ID[7:0];
            default: byte_nxt = mem[cur_addr[MEM_AW-1:0]];
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state   <= ST_CMD;
            cnt     <= 5'd0;
            shreg   <= 8'h00;
            op      <= 8'h00;
            addr    <= 24'd0;
            tx_byte <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= din;
            if (cmd_done) op <= din;
            if (load_byte) begin
                tx_byte <= byte_nxt;
                addr    <= addr_nxt;
            end else if (state == ST_ADDR) begin
                addr <= addr_full;
            end else if (prog_we) begin
                addr <= {addr[23:8], addr[7:0] + 8'd1};
            end
        end
    end

    // Clearing WEL on the first programmed byte is indistinguishable from clearing it at csb rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wel <= 1'b0;
            pd  <= START_PD;
        end else begin
            if (cmd_done && !pd_block) begin
                case (din)
                    OP_WREN: wel <= 1'b1;
                    OP_WRDI: wel <= 1'b0;
                    OP_DP:   pd  <= 1'b1;
                    OP_RES:  pd  <= 1'b0;
                    default: ;
                endcase
            end
            if (prog_we || erase_we) wel <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we) mem[addr[MEM_AW-1:0]] <= mem[addr[MEM_AW-1:0]] & din;
        if (erase_we) begin
            for (int i = 0; i < 4096; i++) mem[{addr_full[MEM_AW-1:12], i[11:0]}] <= 8'hFF;
        end
    end

    always_ff @(negedge clk or posedge areset) begin
        if (areset) begin
            out_oe <= 1'b0;
            out_d  <= 1'b0;
        end else begin
            out_oe <= (state == ST_DOUT);
            out_d  <= tx_byte[3'd7 - cnt[2:0]];
        end
    end

    assign bus.io1_d  = out_d;
    assign bus.io1_oe = out_oe;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed table, hand sequences and random traffic against a command-level flash model
module tb_spi_flash_responder;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    spi_flash_responder_if bus();

    spi_flash_responder #(
        .MEM_AW(20), .INIT_FILE(""), .JEDEC_ID(24'hEF4016), .START_PD(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [23:0] idv = 24'hEF4016;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         rx_all[$];
    bit         rx_any[$];

    logic [7:0] mm[int];
    bit         m_wel, m_pd;
    logic [7:0] expq[$];
    bit         exp_drv[$];

    typedef struct {
        string      name;
        int         ntx;
        logic [7:0] tx[8];
        int         ntot;
        int         idx;
        int         nchk;
        logic [7:0] ex[4];
    } vec_t;
    vec_t vt[$];

    function automatic void add(string name, int ntx, logic [63:0] tx, int ntot, int idx, int nchk, logic [31:0] ex);
        vec_t v;
        v.name = name; v.ntx = ntx; v.ntot = ntot; v.idx = idx; v.nchk = nchk;
        for (int k = 0; k < 8; k++) v.tx[k] = tx[63-8*k -: 8];
        for (int k = 0; k < 4; k++) v.ex[k] = ex[31-8*k -: 8];
        vt.push_back(v);
    endfunction

    function automatic logic [7:0] txb(int i);
        return (i < txq.size()) ? txq[i] : 8'h00;
    endfunction

    function automatic logic [7:0] m_rd(int a);
        int m = a & 32'hFFFFF;
        return mm.exists(m) ? mm[m] : 8'hFF;
    endfunction

    function automatic void set_exp(int i, logic [7:0] b);
        expq[i] = b;
        exp_drv[i] = 1'b1;
    endfunction

    // Command-level model: expected output byte per transferred byte plus state side effects
    function automatic void model_xfer(int n);
        logic [7:0] opc;
        int a, pa, k;
        expq.delete(); exp_drv.delete();
        for (int i = 0; i < n; i++) begin expq.push_back(8'h00); exp_drv.push_back(1'b0); end
        opc = txb(0);
        a = {8'h00, txb(1), txb(2), txb(3)} & 32'hFFFFF;
        if (m_pd && opc != 8'hAB) return;
        case (opc)
            8'h03: for (int i = 4; i < n; i++) set_exp(i, m_rd(a + i - 4));
            8'h0B: for (int i = 5; i < n; i++) set_exp(i, m_rd(a + i - 5));
            8'h9F: for (int i = 1; i < n; i++) begin
                k = i - 1;
                set_exp(i, (k < 3) ? idv[23-8*k -: 8] : 8'hFF);
            end
            8'h05: for (int i = 1; i < n; i++) set_exp(i, {6'b0, m_wel, 1'b0});
            8'h06: m_wel = 1'b1;
            8'h04: m_wel = 1'b0;
            8'hB9: m_pd = 1'b1;
            8'hAB: begin
                m_pd = 1'b0;
                for (int i = 4; i < n; i++) set_exp(i, idv[7:0]);
            end
            8'h02: if (m_wel && n >= 5) begin
                for (int i = 4; i < n; i++) begin
                    pa = (a & 32'hFFF00) | ((a + i - 4) & 32'hFF);
                    mm[pa] = m_rd(pa) & txb(i);
                end
                m_wel = 1'b0;
            end
            8'h20: if (m_wel && n >= 4) begin
                for (int j = 0; j < 4096; j++) mm[(a & 32'hFF000) + j] = 8'hFF;
                m_wel = 1'b0;
            end
            default: ;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction: io0 driven and io1 captured just after each falling edge
    task automatic shift(int nbits);
        logic [7:0] cur, tb;
        int oecnt;
        cur = 8'h00; oecnt = 0;
        rxq.delete(); rx_all.delete(); rx_any.delete();
        @(negedge clk); #1;
        bus.csb = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            tb = txb(i / 8);
            bus.io0 = tb[7 - (i % 8)];
            cur = {cur[6:0], bus.io1_oe ? bus.io1 : 1'b0};
            oecnt += int'(bus.io1_oe);
            if (i % 8 == 7) begin
                rxq.push_back(cur);
                rx_all.push_back(oecnt == 8);
                rx_any.push_back(oecnt != 0);
                oecnt = 0;
            end
        end
        @(negedge clk); #1;
        bus.csb = 1'b1;
        bus.io0 = 1'b0;
        #1;
    endtask

    task automatic compare_model(string name);
        for (int i = 0; i < expq.size(); i++) begin
            if (exp_drv[i]) check($sformatf("%s byte%0d", name, i), {23'd0, rx_all[i], rxq[i]}, {23'd0, 1'b1, expq[i]});
            else            check($sformatf("%s z%0d", name, i), {31'd0, rx_any[i]}, 32'd0);
        end
    endtask

    task automatic mxfer(string name, int n);
        model_xfer(n);
        shift(n * 8);
        compare_model(name);
    endtask

    initial begin
        logic [7:0] ops[12] = '{8'h03, 8'h0B, 8'h9F, 8'h05, 8'h06, 8'h06, 8'h04, 8'h02, 8'h02, 8'h20, 8'hB9, 8'hAB};
        logic [19:0] bases[4] = '{20'h00100, 20'hFFFF8, 20'h01000, 20'h00FFC};
        logic [23:0] ra;
        logic [7:0] opc, tb;
        int n;
        bit anyd;

        rst = 1'b1; bus.csb = 1'b1; bus.io0 = 1'b0; bus.io2 = 1'b1; bus.io3 = 1'b1;
        m_wel = 1'b0; m_pd = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_z", {31'd0, bus.io1_oe}, 32'd0);
        rst = 1'b0;

        add("rdsr_reset",    1, 64'h05 << 56,               2, 1, 1, 32'h00000000);
        add("wren",          1, 64'h06 << 56,               1, 0, 0, 32'h0);
        add("rdsr_wel",      1, 64'h05 << 56,               3, 1, 2, 32'h02020000);
        add("pp_preload",    8, 64'h0200010011223344,       8, 0, 0, 32'h0);
        add("rdsr_after_pp", 1, 64'h05 << 56,               2, 1, 1, 32'h00000000);
        add("read",          4, 64'h0300010000000000,       8, 4, 4, 32'h11223344);
        add("fast_read",     4, 64'h0B00010200000000,       7, 5, 2, 32'h33440000);
        add("wren",          1, 64'h06 << 56,               1, 0, 0, 32'h0);
        add("pp_top",        5, 64'h020FFFFFAA000000,       5, 0, 0, 32'h0);
        add("wren",          1, 64'h06 << 56,               1, 0, 0, 32'h0);
        add("pp_zero",       5, 64'h0200000055000000,       5, 0, 0, 32'h0);
        add("read_wrap",     4, 64'h030FFFFF00000000,       6, 4, 2, 32'hAA550000);
        add("rdid",          1, 64'h9F << 56,               5, 1, 4, 32'hEF4016FF);
        add("wren",          1, 64'h06 << 56,               1, 0, 0, 32'h0);
        add("wrdi",          1, 64'h04 << 56,               1, 0, 0, 32'h0);
        add("rdsr_wrdi",     1, 64'h05 << 56,               2, 1, 1, 32'h00000000);
        add("pp_no_wel",     5, 64'h0200001000000000,       5, 0, 0, 32'h0);
        add("read_no_wel",   4, 64'h0300001000000000,       5, 4, 1, 32'hFF000000);
        add("wren",          1, 64'h06 << 56,               1, 0, 0, 32'h0);
        add("pp_page_wrap",  6, 64'h020000FFF00F0000,       6, 0, 0, 32'h0);
        add("read_ff",       4, 64'h030000FF00000000,       5, 4, 1, 32'hF0000000);
        add("read_0",        4, 64'h0300000000000000,       5, 4, 1, 32'h05000000);
        add("rdsr_pp_done",  1, 64'h05 << 56,               2, 1, 1, 32'h00000000);
        add("wren",          1, 64'h06 << 56,               1, 0, 0, 32'h0);
        add("pp_1000",       5, 64'h0200100077000000,       5, 0, 0, 32'h0);
        add("wren",          1, 64'h06 << 56,               1, 0, 0, 32'h0);
        add("erase",         4, 64'h2000012300000000,       4, 0, 0, 32'h0);
        add("rdsr_erase",    1, 64'h05 << 56,               2, 1, 1, 32'h00000000);
        add("read_erased",   4, 64'h0300000000000000,       8, 4, 4, 32'hFFFFFFFF);
        add("read_edge",     4, 64'h03000FFE00000000,       7, 4, 3, 32'hFFFF7700);
        add("dp",            1, 64'hB9 << 56,               1, 0, 0, 32'h0);
        add("rdid_pd",       1, 64'h9F << 56,               4, 0, 0, 32'h0);
        add("rdsr_pd",       1, 64'h05 << 56,               2, 0, 0, 32'h0);
        add("res",           1, 64'hAB << 56,               1, 0, 0, 32'h0);
        add("rdid_wake",     1, 64'h9F << 56,               4, 1, 3, 32'hEF401600);
        add("dp",            1, 64'hB9 << 56,               1, 0, 0, 32'h0);
        add("res_id",        1, 64'hAB << 56,               6, 4, 2, 32'h16160000);
        add("rdsr_awake",    1, 64'h05 << 56,               2, 1, 1, 32'h00000000);
        add("unknown_op",    3, 64'h5A00000000000000,       3, 0, 0, 32'h0);

        foreach (vt[j]) begin
            txq.delete();
            for (int k = 0; k < vt[j].ntx; k++) txq.push_back(vt[j].tx[k]);
            model_xfer(vt[j].ntot);
            shift(vt[j].ntot * 8);
            if (vt[j].nchk == 0) begin
                anyd = 1'b0;
                foreach (rx_any[k]) anyd |= rx_any[k];
                check({vt[j].name, " z"}, {31'd0, anyd}, 32'd0);
            end else begin
                for (int k = 0; k < vt[j].nchk; k++)
                    check(vt[j].name, {23'd0, rx_all[vt[j].idx + k], rxq[vt[j].idx + k]}, {23'd0, 1'b1, vt[j].ex[k]});
            end
            check({vt[j].name, " idle_z"}, {31'd0, bus.io1_oe}, 32'd0);
        end

        // Erase aborted mid-address and program aborted mid-byte leave WEL and memory alone
        txq = '{8'h06}; mxfer("abort_wren", 1);
        txq = '{8'h20, 8'h00, 8'h01}; shift(20);
        txq = '{8'h05}; mxfer("abort_se_rdsr", 2);
        txq = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h00}; shift(36);
        txq = '{8'h05}; mxfer("abort_pp_rdsr", 2);
        txq = '{8'h03, 8'h00, 8'h02, 8'h00}; mxfer("abort_pp_read", 5);
        txq = '{8'h06}; mxfer("reprog_wren", 1);
        txq = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h5C}; mxfer("reprog", 5);

        // Reset in the middle of a read: io1 releases at once and the next read is clean
        txq = '{8'h03, 8'h00, 8'h01, 8'h00};
        @(negedge clk); #1;
        bus.csb = 1'b0;
        for (int i = 0; i < 36; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            tb = txb(i / 8);
            bus.io0 = (i < 32) ? tb[7 - (i % 8)] : 1'b0;
        end
        check("oe_before_rst", {31'd0, bus.io1_oe}, 32'd1);
        rst = 1'b1;
        #1 check("rst_z", {31'd0, bus.io1_oe}, 32'd0);
        @(negedge clk); #1;
        bus.csb = 1'b1; bus.io0 = 1'b0; rst = 1'b0;
        m_wel = 1'b0; m_pd = 1'b0;
        txq = '{8'h05}; mxfer("post_rst_rdsr", 2);
        txq = '{8'h03, 8'h00, 8'h01, 8'h00}; mxfer("post_rst_read", 6);

        for (int it = 0; it < 80; it++) begin
            opc = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) opc = 8'h5A;
            ra = {4'($urandom), bases[$urandom_range(0, 3)] + 20'($urandom_range(0, 7))};
            case (opc)
                8'h03:   n = 4 + $urandom_range(0, 6);
                8'h0B:   n = 5 + $urandom_range(0, 6);
                8'h9F:   n = 1 + $urandom_range(0, 5);
                8'h05:   n = 1 + $urandom_range(0, 3);
                8'h02:   n = 4 + $urandom_range(0, 4);
                8'h20:   n = 4;
                8'hAB:   n = ($urandom_range(0, 1) == 0) ? 1 : 4 + $urandom_range(0, 3);
                8'h5A:   n = 1 + $urandom_range(0, 4);
                default: n = 1;
            endcase
            txq.delete();
            txq.push_back(opc);
            if (opc == 8'h03 || opc == 8'h0B || opc == 8'h02 || opc == 8'h20) begin
                txq.push_back(ra[23:16]); txq.push_back(ra[15:8]); txq.push_back(ra[7:0]);
                for (int k = 4; k < n; k++) txq.push_back(8'($urandom));
            end
            mxfer($sformatf("rand%0d_op%02h", it, opc), n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
